bresenham_line_stream: RTL
==========================

Name: bresenham_line_stream

Overview:
- Parametrised, all-octant Bresenham line rasteriser.
- Accepts one line command (two endpoints plus colour) through a start/busy/done handshake.
- Emits the line's pixels one per cycle on a valid/ready stream with a last flag.
- Sits upstream of the framebuffer writer and replaces per-sprite hcount/vcount comparison; any slope and any endpoint order are supported.

Parameters:
- X_WIDTH, 11, width of x coordinates.
- Y_WIDTH, 10, width of y coordinates.
- COLOR_WIDTH, 24, pixel colour width (RGB888 default).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  command strobe; sampled only in IDLE.
- x1_in  input  X_WIDTH  start x.
- y1_in  input  Y_WIDTH  start y.
- x2_in  input  X_WIDTH  end x.
- y2_in  input  Y_WIDTH  end y.
- color_in  input  COLOR_WIDTH  line colour, latched with the endpoints.
- abort_in  input  1  cancel the current command.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse after the last pixel is accepted.
- pix_valid_out  output  1  pixel present.
- pix_ready_in  input  1  consumer accepts the pixel.
- pix_x_out  output  X_WIDTH  pixel x.
- pix_y_out  output  Y_WIDTH  pixel y.
- pix_color_out  output  COLOR_WIDTH  latched colour.
- pix_last_out  output  1  final pixel of the line.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; all outputs 0; internal registers 0.
- FSM states:
  - IDLE -> SETUP on start_in. x1, y1, x2, y2 and colour are latched.
  - SETUP (exactly 1 cycle) computes:
    - W = max(X_WIDTH, Y_WIDTH) + 2, signed.
    - dx = |x2 - x1|; dy = -|y2 - y1|.
    - sx = +1 if x2 >= x1, else -1; sy = +1 if y2 >= y1, else -1.
    - err = dx + dy.
    - Current point = (x1, y1). Go to DRAW.
  - DRAW:
    - pix_valid_out = 1; pix_x_out/pix_y_out are the current-point registers.
    - pix_last_out = (cur == (x2, y2)).
  - DONE (1 cycle): done_out = 1, then IDLE.
- Stepping, on pix_valid_out && pix_ready_in in DRAW:
  - If last: go to DONE.
  - Otherwise e2 = 2*err (W+1 bits signed). Both tests below use the pre-update err and are summed into one err update in the same cycle:
    - if e2 >= dy: err += dy, x += sx.
    - if e2 <= dx: err += dx, y += sy.
- Stream rules: x, y, colour and last are held stable while valid && !ready. Valid never drops without acceptance, except on abort.
- Throughput and latency:
  - 1 pixel/cycle with ready held high.
  - start accepted at cycle N -> first valid at N+2.
  - Pixel count = max(|dx|, |dy|) + 1.
  - done_out fires the cycle after the last handshake.
- Boundary conditions:
  - Degenerate line (x1 == x2 and y1 == y2): exactly one pixel, with last = 1.
  - start_in while busy: ignored; latched endpoints unchanged.
  - start_in in the same cycle as DONE: ignored; must be re-asserted in IDLE.
  - abort_in in SETUP, DRAW or DONE: next cycle IDLE, valid = 0, no done pulse. abort_in has priority over a simultaneous handshake.
  - abort_in in IDLE: no effect; if start_in is asserted in the same cycle, abort wins and the start is dropped.
  - Reset mid-line: immediate IDLE, no residual pixels.
  - No coordinate wrap is possible: the walk stays within the endpoint bounding box by construction. The bench asserts this.

Decomposition:
- Package line_pkg holds:
  - enum line_state_t {IDLE, SETUP, DRAW, DONE};
  - localparam function for W.
  - A typedef for the signed error term.
- No sub-module: setup and stepping are short datapaths and stay inline in one always_ff plus one always_comb.

Test Plan:
- Horizontal line, start (0,0)->(3,0), ready = 1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles; last on (3,0); done 1 cycle later.
- Steep negative octant, (10,10)->(12,4) -> exactly (10,10),(10,9),(11,8),(11,7),(11,6),(12,5),(12,4); 7 pixels; last only on (12,4).
- Degenerate, (5,5)->(5,5) -> one pixel (5,5) with valid and last together; done next cycle; busy low after.
- Backpressure, (0,0)->(7,3) with ready toggling 1-0-0-1 randomly -> outputs stable while stalled; 8 pixels total; sequence identical to the ready = 1 run.
- Abort/start interaction:
  - start (0,0)->(20,0); assert start_in with new endpoints mid-draw -> ignored.
  - abort after the 5th accept -> valid = 0 next cycle, no done, busy = 0.
  - A new start then draws normally.
- Async reset mid-line, (0,0)->(100,50), rst_in low between clock edges -> all outputs 0 immediately; after release the block stays IDLE until start.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types and helpers for the Bresenham line rasteriser.
package line_pkg;

  // Command FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_state_t;

  // Wide signed type used while deriving the deltas from the latched endpoints.
  typedef logic signed [31:0] line_err_t;

  // Width of the signed error/delta terms: wide enough to hold +|dx| and -|dy|.
  function automatic int line_err_w(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/bresenham_line_stream.sv
// All-octant Bresenham line rasteriser: one command in, one pixel per cycle out.
module bresenham_line_stream
  import line_pkg::*;
#(
  parameter int X_WIDTH     = 11,
  parameter int Y_WIDTH     = 10,
  parameter int COLOR_WIDTH = 24
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [X_WIDTH-1:0]     x1_in,
  input  logic [Y_WIDTH-1:0]     y1_in,
  input  logic [X_WIDTH-1:0]     x2_in,
  input  logic [Y_WIDTH-1:0]     y2_in,
  input  logic [COLOR_WIDTH-1:0] color_in,
  input  logic                   abort_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   pix_valid_out,
  input  logic                   pix_ready_in,
  output logic [X_WIDTH-1:0]     pix_x_out,
  output logic [Y_WIDTH-1:0]     pix_y_out,
  output logic [COLOR_WIDTH-1:0] pix_color_out,
  output logic                   pix_last_out
);

  localparam int W = line_err_w(X_WIDTH, Y_WIDTH);
  localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
  localparam logic [X_WIDTH-1:0] X_M1  = {X_WIDTH{1'b1}};
  localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_M1  = {Y_WIDTH{1'b1}};

  line_state_t             state_q, state_d;
  logic [X_WIDTH-1:0]      x1_q, x1_d, x2_q, x2_d, cur_x_q, cur_x_d;
  logic [Y_WIDTH-1:0]      y1_q, y1_d, y2_q, y2_d, cur_y_q, cur_y_d;
  logic [COLOR_WIDTH-1:0]  color_q, color_d;
  logic signed [W-1:0]     dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  line_err_t               ddx_s, ddy_s, adx_s, ady_s;
  logic signed [W:0]       e2_s;
  logic                    step_x_s, step_y_s, at_end_s;

  assign at_end_s      = (state_q == DRAW) && (cur_x_q == x2_q) && (cur_y_q == y2_q);
  assign busy_out      = (state_q != IDLE);
  assign done_out      = (state_q == DONE);
  assign pix_valid_out = (state_q == DRAW);
  assign pix_x_out     = cur_x_q;
  assign pix_y_out     = cur_y_q;
  assign pix_color_out = color_q;
  assign pix_last_out  = at_end_s;

  // Next-state, setup arithmetic and per-pixel stepping.
  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    color_d  = color_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    ddx_s = line_err_t'(x2_q) - line_err_t'(x1_q);
    ddy_s = line_err_t'(y2_q) - line_err_t'(y1_q);
    adx_s = (ddx_s < 32'sd0) ? -ddx_s : ddx_s;
    ady_s = (ddy_s < 32'sd0) ? -ddy_s : ddy_s;

    // Both step decisions look at the error term before this cycle's update.
    e2_s     = $signed({err_q, 1'b0});
    step_x_s = (e2_s >= dy_q);
    step_y_s = (e2_s <= dx_q);

    case (state_q)
      IDLE: begin
        if (abort_in) begin
          state_d = IDLE;
        end else if (start_in) begin
          x1_d    = x1_in;
          y1_d    = y1_in;
          x2_d    = x2_in;
          y2_d    = y2_in;
          color_d = color_in;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (abort_in) begin
          state_d = IDLE;
        end else begin
          dx_d     = W'(adx_s);
          dy_d     = -W'(ady_s);
          err_d    = W'(adx_s - ady_s);
          sx_neg_d = (ddx_s < 32'sd0);
          sy_neg_d = (ddy_s < 32'sd0);
          cur_x_d  = x1_q;
          cur_y_d  = y1_q;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (abort_in) begin
          state_d = IDLE;
        end else if (pix_ready_in) begin
          if (at_end_s) begin
            state_d = DONE;
          end else begin
            err_d = err_q + (step_x_s ? dy_q : {W{1'b0}}) + (step_y_s ? dx_q : {W{1'b0}});
            if (step_x_s) begin
              cur_x_d = cur_x_q + (sx_neg_q ? X_M1 : X_ONE);
            end else begin
              cur_x_d = cur_x_q;
            end
            if (step_y_s) begin
              cur_y_d = cur_y_q + (sy_neg_q ? Y_M1 : Y_ONE);
            end else begin
              cur_y_d = cur_y_q;
            end
          end
        end else begin
          state_d = DRAW;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      x1_q     <= {X_WIDTH{1'b0}};
      y1_q     <= {Y_WIDTH{1'b0}};
      x2_q     <= {X_WIDTH{1'b0}};
      y2_q     <= {Y_WIDTH{1'b0}};
      cur_x_q  <= {X_WIDTH{1'b0}};
      cur_y_q  <= {Y_WIDTH{1'b0}};
      color_q  <= {COLOR_WIDTH{1'b0}};
      dx_q     <= {W{1'b0}};
      dy_q     <= {W{1'b0}};
      err_q    <= {W{1'b0}};
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      color_q  <= color_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule
